// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  // First set bit of req_mask scanning upward from ptr, wrapping at num (max 4).
  function automatic logic [1:0] rr_next(input logic [1:0] ptr,
                                         input logic [3:0] req_mask,
                                         input int         num);
    int idx;
    rr_next = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (k < num) begin
        idx = (int'(ptr) + k) % num;
        if (req_mask[idx]) rr_next = idx[1:0];
      end
    end
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Round-robin winner selection with a registered priority pointer.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 1
) (
  input  logic               sclk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  input  logic [ID_W-1:0]    i_last_id,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_winner
);

  logic [ID_W-1:0] r_ptr;
  logic [3:0]      w_mask;
  logic [1:0]      w_win;

  always_comb begin
    w_mask = '0;
    w_mask[NUM_REQ-1:0] = i_req;
    w_win = rr_next(2'(r_ptr), w_mask, NUM_REQ);
  end

  assign o_valid  = |i_req;
  assign o_winner = w_win[ID_W-1:0];

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (i_last_id == ID_W'(NUM_REQ - 1)) ? '0 : i_last_id + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin grants.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       sclk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rdata,
  output logic                       err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [ADDR_W-1:0]          b_paddr,
  output logic                       b_pwrite,
  output logic [DATA_W-1:0]          b_pwdata,
  output logic                       b_psel,
  output logic                       b_penable,
  input  logic [DATA_W-1:0]          b_prdata,
  input  logic                       b_pready
);

  localparam int ID_W = $clog2(NUM_REQ);

  apb_state_t         r_state;
  logic               r_psel;
  logic               r_penable;
  logic [ADDR_W-1:0]  r_paddr;
  logic               r_pwrite;
  logic [DATA_W-1:0]  r_pwdata;
  logic [NUM_REQ-1:0] r_done;
  logic [DATA_W-1:0]  r_rdata;
  logic [ID_W-1:0]    r_grant;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_any;
  logic [ID_W-1:0]    w_winner;
  logic               w_tmo;
  logic               w_finish;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  assign w_tmo = (r_tmo == '0);
  assign err   = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  // A requester still holding req during its own done pulse must not win again.
  assign w_elig   = req & ~r_done;
  assign w_finish = (r_state == ST_ACCESS) && (b_pready || w_tmo);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .sclk      (sclk),
    .reset     (reset),
    .i_req     (w_elig),
    .i_advance (w_finish),
    .i_last_id (r_grant),
    .o_valid   (w_any),
    .o_winner  (w_winner)
  );

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_grant   <= '0;
`ifdef APB_TIMEOUT_EN
      r_tmo     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant  <= w_winner;
            r_paddr  <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
            r_pwdata <= req_wdata[int'(w_winner)*DATA_W +: DATA_W];
            r_pwrite <= req_write[w_winner];
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          r_tmo     <= TMO_W'(TIMEOUT_CYC - 1);
`endif
        end
        ST_ACCESS: begin
          if (w_finish) begin
            r_psel          <= 1'b0;
            r_penable       <= 1'b0;
            r_state         <= ST_IDLE;
            r_done[r_grant] <= 1'b1;
            // pready wins over a coincident timeout
            r_rdata         <= (r_pwrite || !b_pready) ? '0 : b_prdata;
`ifdef APB_TIMEOUT_EN
            r_err           <= !b_pready;
`endif
          end
`ifdef APB_TIMEOUT_EN
          else begin
            r_tmo <= r_tmo - 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign grant_id  = r_grant;
  assign b_paddr   = r_paddr;
  assign b_pwrite  = r_pwrite;
  assign b_pwdata  = r_pwdata;
  assign b_psel    = r_psel;
  assign b_penable = r_penable;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter; timeout cases run when APB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  logic                      sclk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic [0:0]                grant_id;
  logic [ADDR_W-1:0]         b_paddr;
  logic                      b_pwrite;
  logic [DATA_W-1:0]         b_pwdata;
  logic                      b_psel;
  logic                      b_penable;
  logic [DATA_W-1:0]         b_prdata;
  logic                      b_pready;

  apb_master_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .sclk      (sclk),
    .reset     (reset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .grant_id  (grant_id),
    .b_paddr   (b_paddr),
    .b_pwrite  (b_pwrite),
    .b_pwdata  (b_pwdata),
    .b_psel    (b_psel),
    .b_penable (b_penable),
    .b_prdata  (b_prdata),
    .b_pready  (b_pready)
  );

  typedef struct {
    int                id;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   slv_wait = 0;
  int   acc_cnt  = 0;

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // APB slave: pready after slv_wait ACCESS cycles, driven away from the active edge
  always @(negedge sclk) begin
    if (b_psel && b_penable) begin
      b_pready = (acc_cnt == slv_wait);
      acc_cnt++;
    end else begin
      b_pready = 1'b0;
      acc_cnt  = 0;
    end
  end

  // Scoreboard: every done pulse must match the oldest expectation
  always @(negedge sclk) begin
    exp_t e;
    if (!reset && (done != '0)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_done",  32'(done),     32'(1 << e.id));
        check_eq("sb_grant", 32'(grant_id), 32'(e.id));
        check_eq("sb_rdata", 32'(rdata),    32'(e.rdata));
        check_eq("sb_err",   32'(err),      32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wd);
    req_write[id]           = wr;
    req_addr[id*ADDR_W +: ADDR_W]  = addr;
    req_wdata[id*DATA_W +: DATA_W] = wd;
    req[id]                 = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic [7:0] rd, input logic e);
    exp_t x;
    x.id = id; x.rdata = rd; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic wait_done(input int id, output int pen_cyc);
    pen_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (b_penable) pen_cyc++;
      if (done[id]) break;
    end
    check_eq("done_seen", 32'(done[id]), 32'd1);
  endtask

  initial begin
    int pen;
    int ndone;
    int k;
    reset     = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    b_prdata  = 8'h3C;
    repeat (2) step();

    check_eq("rst_psel",    32'(b_psel),    32'd0);
    check_eq("rst_penable", 32'(b_penable), 32'd0);
    check_eq("rst_paddr",   32'(b_paddr),   32'd0);
    check_eq("rst_pwdata",  32'(b_pwdata),  32'd0);
    check_eq("rst_pwrite",  32'(b_pwrite),  32'd0);
    check_eq("rst_done",    32'(done),      32'd0);
    check_eq("rst_rdata",   32'(rdata),     32'd0);
    check_eq("rst_err",     32'(err),       32'd0);
    check_eq("rst_grant",   32'(grant_id),  32'd0);
    reset = 1'b0;
    step();

    // single zero-wait write from req0: exact cycle timing
    slv_wait = 0;
    set_req(0, 1'b1, 8'h12, 8'hA5);
    push_exp(0, 8'h00, 1'b0);
    step();
    check_eq("w_setup_psel",    32'(b_psel),    32'd1);
    check_eq("w_setup_penable", 32'(b_penable), 32'd0);
    check_eq("w_paddr",         32'(b_paddr),   32'h12);
    check_eq("w_pwdata",        32'(b_pwdata),  32'hA5);
    check_eq("w_pwrite",        32'(b_pwrite),  32'd1);
    step();
    check_eq("w_access_psel",    32'(b_psel),    32'd1);
    check_eq("w_access_penable", 32'(b_penable), 32'd1);
    step();
    check_eq("w_done_cycle", 32'(done),   32'b01);
    check_eq("w_done_psel",  32'(b_psel), 32'd0);
    req[0] = 1'b0;
    step();

    // read from req1 with three wait states
    slv_wait = 3;
    b_prdata = 8'h3C;
    set_req(1, 1'b0, 8'h40, 8'h00);
    push_exp(1, 8'h3C, 1'b0);
    wait_done(1, pen);
    check_eq("rd_penable_cycles", 32'(pen), 32'd4);
    req[1] = 1'b0;
    step();

    // both requesters held: strict alternation 0,1,0,1,0,1
    slv_wait = 0;
    set_req(0, 1'b1, 8'h20, 8'h11);
    set_req(1, 1'b0, 8'h21, 8'h00);
    for (int i = 0; i < 6; i++) push_exp(i % 2, (i % 2) ? 8'h3C : 8'h00, 1'b0);
    ndone = 0;
    k = 0;
    while (k < 100 && ndone < 6) begin
      step();
      k++;
      if (done != '0) ndone++;
    end
    check_eq("rr_ndone",  32'(ndone), 32'd6);
    check_eq("rr_cycles", 32'(k),     32'd18);
    req = '0;
    step();

    // move pointer to 1, then reset in ACCESS of a req0 transfer
    set_req(0, 1'b1, 8'h30, 8'h55);
    push_exp(0, 8'h00, 1'b0);
    wait_done(0, pen);
    req[0] = 1'b0;
    step();
    slv_wait = 1000;
    set_req(0, 1'b1, 8'h31, 8'h66);
    for (int i = 0; i < 20 && !b_penable; i++) step();
    check_eq("rst_mid_in_access", 32'(b_penable), 32'd1);
    step();
    reset = 1'b1;
    step();
    check_eq("rst_mid_psel",    32'(b_psel),    32'd0);
    check_eq("rst_mid_penable", 32'(b_penable), 32'd0);
    check_eq("rst_mid_done",    32'(done),      32'd0);
    reset    = 1'b0;
    slv_wait = 0;
    set_req(1, 1'b0, 8'h32, 8'h00);
    push_exp(0, 8'h00, 1'b0);
    push_exp(1, 8'h3C, 1'b0);
    step();
    check_eq("rst_regrant_id",    32'(grant_id), 32'd0);
    check_eq("rst_regrant_paddr", 32'(b_paddr),  32'h31);
    wait_done(0, pen);
    req[0] = 1'b0;
    wait_done(1, pen);
    req[1] = 1'b0;
    step();

    // req1 raised during req0's done pulse; req0 left high
    set_req(0, 1'b1, 8'h40, 8'h77);
    push_exp(0, 8'h00, 1'b0);
    wait_done(0, pen);
    set_req(1, 1'b0, 8'h41, 8'h00);
    push_exp(1, 8'h3C, 1'b0);
    step();
    check_eq("late_req1_grant", 32'(grant_id), 32'd1);
    check_eq("late_req1_paddr", 32'(b_paddr),  32'h41);
    check_eq("late_req1_psel",  32'(b_psel),   32'd1);
    req[0] = 1'b0;
    wait_done(1, pen);
    req[1] = 1'b0;
    step();

    // stale req0 held through its done pulse must not be re-granted
    set_req(0, 1'b1, 8'h50, 8'h88);
    push_exp(0, 8'h00, 1'b0);
    wait_done(0, pen);
    step();
    check_eq("mask_no_regrant", 32'(b_psel), 32'd0);
    req[0] = 1'b0;
    step();

`ifdef APB_TIMEOUT_EN
    slv_wait = 1000;
    set_req(0, 1'b1, 8'h60, 8'h99);
    push_exp(0, 8'h00, 1'b1);
    wait_done(0, pen);
    check_eq("tmo_penable_cycles", 32'(pen), 32'd16);
    req[0] = 1'b0;
    step();
    slv_wait = 0;
    set_req(1, 1'b0, 8'h61, 8'h00);
    push_exp(1, 8'h3C, 1'b0);
    wait_done(1, pen);
    req[1] = 1'b0;
    step();
    slv_wait = 15;
    b_prdata = 8'h5A;
    set_req(0, 1'b0, 8'h62, 8'h00);
    push_exp(0, 8'h5A, 1'b0);
    wait_done(0, pen);
    check_eq("tmo_edge_penable_cycles", 32'(pen), 32'd16);
    req[0] = 1'b0;
    step();
`endif

    repeat (5) step();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
